// File: rtl/soda_machine.sv
// -----------------------------------------------------------------------------
// soda_machine
//
// Purpose:
//   Coin-accumulating vending controller for one product at a fixed price.
//   Each rising edge of the coin-present level adds the presented coin value
//   to a saturating running total. Once the total reaches PRICE, the block
//   raises a one-cycle dispense strobe and then settles the credit.
//
// Parameters:
//   W      width of the coin value bus and of the running total
//   PRICE  product price in coin units (1 .. 2^W-1)
//
// Ports:
//   clk   input        system clock, rising edge
//   rst   input        asynchronous active-low reset
//   c     input        coin-present level, high for one or more cycles per coin
//   a     input  [W]   value of the presented coin, valid while c is high
//   tot   output [W]   registered running credit total
//   d     output       registered dispense strobe, one cycle per vend
//
// Build option:
//   SODA_MACHINE_CARRY_CREDIT_EN  when defined, leaving DISP subtracts PRICE
//                                 from the total so excess credit carries to
//                                 the next vend; otherwise the total is cleared.
//
// State  | meaning
// -------+-----------------------------------------------------------------
// INIT   | post-reset / post-vend settle, moves to WAIT unconditionally
// WAIT   | idle; accepts coins (new or pending) or starts a vend
// ADD    | adds the captured coin value to the total (saturating)
// DISP   | dispense strobe high for this single cycle, then settle credit
// -----------------------------------------------------------------------------
module soda_machine #(
  parameter int W     = 8,
  parameter int PRICE = 75
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c,
  input  logic [W-1:0] a,
  output logic [W-1:0] tot,
  output logic         d
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_WAIT = 2'd1,
    ST_ADD  = 2'd2,
    ST_DISP = 2'd3
  } state_t;

  localparam logic [W-1:0] L_PRICE = PRICE[W-1:0];

  state_t       r_state;
  logic [W-1:0] r_tot;
  logic         r_d;
  logic         r_c_prev;
  logic         r_pend;
  logic [W-1:0] r_a_reg;

  logic         w_coin;
  logic [W:0]   w_sum;
  logic [W-1:0] w_add_sat;
  logic [W-1:0] w_settle;

  assign w_coin    = c & ~r_c_prev;
  assign w_sum     = {1'b0, r_tot} + {1'b0, r_a_reg};
  // Carry out of the add means the true sum exceeds the bus; clamp to all ones.
  assign w_add_sat = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];

`ifdef SODA_MACHINE_CARRY_CREDIT_EN
  // DISP is only entered with r_tot >= PRICE, so this cannot underflow.
  assign w_settle = r_tot - L_PRICE;
`else
  assign w_settle = {W{1'b0}};
`endif

  assign tot = r_tot;
  assign d   = r_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_INIT;
      r_tot    <= {W{1'b0}};
      r_d      <= 1'b0;
      r_c_prev <= 1'b0;
      r_pend   <= 1'b0;
      r_a_reg  <= {W{1'b0}};
    end else begin
      r_c_prev <= c;
      case (r_state)
        ST_INIT: begin
          r_state <= ST_WAIT;
          // One-deep holding slot: a second coin while one is pending is lost.
          if (w_coin && !r_pend) begin
            r_pend  <= 1'b1;
            r_a_reg <= a;
          end
        end

        ST_WAIT: begin
          if (r_pend) begin
            // r_a_reg already holds the pending coin. A new edge landing in
            // this exact cycle has no free slot and is dropped.
            r_pend  <= 1'b0;
            r_state <= ST_ADD;
          end else if (w_coin) begin
            // Coin beats a vend in the same cycle so credit is added first.
            r_a_reg <= a;
            r_state <= ST_ADD;
          end else if (r_tot >= L_PRICE) begin
            r_d     <= 1'b1;
            r_state <= ST_DISP;
          end
        end

        ST_ADD: begin
          r_tot   <= w_add_sat;
          r_state <= ST_WAIT;
          if (w_coin && !r_pend) begin
            r_pend  <= 1'b1;
            r_a_reg <= a;
          end
        end

        ST_DISP: begin
          r_d     <= 1'b0;
          r_tot   <= w_settle;
          r_state <= ST_INIT;
          if (w_coin && !r_pend) begin
            r_pend  <= 1'b1;
            r_a_reg <= a;
          end
        end

        default: begin
          r_d     <= 1'b0;
          r_state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soda_machine.sv
module tb_soda_machine;

  logic       clk;
  logic       rst;
  logic       c;
  logic [7:0] a;
  logic [7:0] tot1;
  logic       d1;
  logic [7:0] tot2;
  logic       d2;

  int n_checks;
  int n_fail;
  int n_d1;
  int n_d2;
  int base;

`ifdef SODA_MACHINE_CARRY_CREDIT_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  // Default-price unit and a PRICE=255 unit for the saturation scenario.
  soda_machine #(.W(8), .PRICE(75)) dut (
    .clk (clk),
    .rst (rst),
    .c   (c),
    .a   (a),
    .tot (tot1),
    .d   (d1)
  );

  soda_machine #(.W(8), .PRICE(255)) dut_sat (
    .clk (clk),
    .rst (rst),
    .c   (c),
    .a   (a),
    .tot (tot2),
    .d   (d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (d1) n_d1++;
    if (d2) n_d2++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one coin: c high for 'hold' rising edges, then one low edge.
  task automatic coin(input logic [7:0] v, input int hold);
    a = v;
    c = 1'b1;
    repeat (hold) tick();
    c = 1'b0;
    tick();
  endtask

  // Leaves the bench at posedge+1 with both units in WAIT.
  task automatic do_reset();
    c   = 1'b0;
    a   = 8'd0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      c = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      @(negedge clk);
      n_checks++;
      if (tot1 !== 8'd0 || d1 !== 1'b0 || tot2 !== 8'd0) begin
        $display("FAIL reset_hold[%0d]: tot=%0d d=%0d tot_sat=%0d, required 0 0 0", i, tot1, d1, tot2);
        n_fail++;
      end
    end
    tick();
    c = 1'b0;
    tick();
    rst = 1'b1;
    base = n_d1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (tot1 !== 8'd0 || d1 !== 1'b0) begin
        $display("FAIL reset_release[%0d]: tot=%0d d=%0d, required 0 0", i, tot1, d1);
        n_fail++;
      end
    end
    tick();
  endtask

  task automatic test_exact_payment();
    do_reset();
    base = n_d1;
    coin(8'd25, 3);
    @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd25) begin
      $display("FAIL exact_first_coin: tot=%0d, required 25", tot1);
      n_fail++;
    end
    tick();
    coin(8'd50, 1);
    @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd75 || d1 !== 1'b0) begin
      $display("FAIL exact_total: tot=%0d d=%0d, required 75 0", tot1, d1);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (d1 !== 1'b1) begin
      $display("FAIL exact_dispense: d=%0d, required 1", d1);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd0 || d1 !== 1'b0) begin
      $display("FAIL exact_settle: tot=%0d d=%0d, required 0 0", tot1, d1);
      n_fail++;
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (n_d1 - base !== 1 || tot1 !== 8'd0) begin
      $display("FAIL exact_pulse_count: pulses=%0d tot=%0d, required 1 0", n_d1 - base, tot1);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_overpay();
    logic [7:0] rem;
    rem = CARRY ? 8'd25 : 8'd0;
    do_reset();
    base = n_d1;
    coin(8'd50, 1);
    coin(8'd50, 1);
    @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd100) begin
      $display("FAIL overpay_total: tot=%0d, required 100", tot1);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (d1 !== 1'b1) begin
      $display("FAIL overpay_dispense: d=%0d, required 1", d1);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (tot1 !== rem || d1 !== 1'b0) begin
      $display("FAIL overpay_settle: tot=%0d d=%0d, required %0d 0", tot1, d1, rem);
      n_fail++;
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (n_d1 - base !== 1 || tot1 !== rem) begin
      $display("FAIL overpay_final: pulses=%0d tot=%0d, required 1 %0d", n_d1 - base, tot1, rem);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_zero_coin();
    do_reset();
    base = n_d1;
    coin(8'd30, 1);
    coin(8'd0, 2);
    repeat (3) @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd30 || n_d1 - base !== 0) begin
      $display("FAIL zero_coin: tot=%0d pulses=%0d, required 30 0", tot1, n_d1 - base);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_coin_priority();
    logic [7:0] rem;
    rem = CARRY ? 8'd10 : 8'd0;
    do_reset();
    base = n_d1;
    coin(8'd50, 1);
    a = 8'd25;
    c = 1'b1;
    tick();
    c = 1'b0;
    tick();
    // Total just reached 75 and a new coin edge arrives in the same WAIT cycle.
    a = 8'd10;
    c = 1'b1;
    tick();
    c = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1 !== 1'b0 || tot1 !== 8'd75) begin
      $display("FAIL priority_no_early_vend: d=%0d tot=%0d, required 0 75", d1, tot1);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd85) begin
      $display("FAIL priority_added: tot=%0d, required 85", tot1);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (d1 !== 1'b1) begin
      $display("FAIL priority_dispense: d=%0d, required 1", d1);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (tot1 !== rem || n_d1 - base !== 1) begin
      $display("FAIL priority_settle: tot=%0d pulses=%0d, required %0d 1", tot1, n_d1 - base, rem);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_coin_during_vend();
    do_reset();
    base = n_d1;
    coin(8'd25, 1);
    coin(8'd50, 1);
    @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd75) begin
      $display("FAIL vendcoin_total: tot=%0d, required 75", tot1);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (d1 !== 1'b1) begin
      $display("FAIL vendcoin_dispense: d=%0d, required 1", d1);
      n_fail++;
    end
    a = 8'd25;
    c = 1'b1;
    tick();
    c = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd0 || d1 !== 1'b0) begin
      $display("FAIL vendcoin_settle: tot=%0d d=%0d, required 0 0", tot1, d1);
      n_fail++;
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd25 || n_d1 - base !== 1) begin
      $display("FAIL vendcoin_pending: tot=%0d pulses=%0d, required 25 1", tot1, n_d1 - base);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    base = n_d2;
    coin(8'd200, 1);
    coin(8'd100, 1);
    @(negedge clk);
    n_checks++;
    if (tot2 !== 8'd255) begin
      $display("FAIL sat_total: tot=%0d, required 255", tot2);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (d2 !== 1'b1) begin
      $display("FAIL sat_dispense: d=%0d, required 1", d2);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (tot2 !== 8'd0) begin
      $display("FAIL sat_settle: tot=%0d, required 0", tot2);
      n_fail++;
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (n_d2 - base !== 1) begin
      $display("FAIL sat_pulse_count: pulses=%0d, required 1", n_d2 - base);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    base = n_d1;
    coin(8'd25, 1);
    a = 8'd25;
    c = 1'b1;
    tick();
    c = 1'b0;
    // Now in ADD with credit 25; drop reset between clock edges.
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (tot1 !== 8'd0 || d1 !== 1'b0) begin
      $display("FAIL async_reset_immediate: tot=%0d d=%0d, required 0 0", tot1, d1);
      n_fail++;
    end
    tick();
    rst = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (tot1 !== 8'd0 || n_d1 - base !== 0) begin
      $display("FAIL async_reset_after: tot=%0d pulses=%0d, required 0 0", tot1, n_d1 - base);
      n_fail++;
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_d1     = 0;
    n_d2     = 0;
    base     = 0;
    rst      = 1'b0;
    c        = 1'b0;
    a        = 8'd0;
    test_reset();
    test_exact_payment();
    test_overpay();
    test_zero_coin();
    test_coin_priority();
    test_coin_during_vend();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soda_machine.md
Name: soda_machine

Overview:
- Coin-accumulating vending controller for a single product at a fixed price.
- Each coin-insert event adds the presented coin value to a running total.
- When the total reaches the price, the block pulses a one-cycle dispense strobe, then settles the credit.
- Sits between the coin-acceptor front end (coin strobe plus value bus) and the dispense actuator driver.

Parameters:
- W, 8, width of the coin value bus and of the running total.
- PRICE, 75, product price in coin units; legal range 1 to 2^W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- c  input  1  coin-present level from the acceptor; held high for one or more cycles per coin.
- a  input  W  value of the coin currently presented; valid whenever c is high.
- tot  output  W  registered running credit total.
- d  output  1  registered dispense strobe; high for exactly one cycle per vend.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=INIT, tot=0, d=0.
  - c_prev=0, pend=0, a_reg=0.
  - On rst deassertion, operation starts at the next clk edge.
- Coin event detection:
  - c_prev is a register holding c from the previous cycle.
  - A coin event is a rising edge of c: c=1 and c_prev=0.
  - Holding c high for many cycles counts as one coin.
- Coin capture:
  - On a coin event, a is captured into a_reg at that clock edge.
- FSM states: INIT, WAIT, ADD, DISP (Moore).
  - INIT: unconditional move to WAIT.
  - WAIT, on a coin event (or with pend=1): clear pend, go to ADD.
  - WAIT, otherwise if tot >= PRICE: go to DISP.
  - WAIT, otherwise: stay.
  - ADD: tot <= tot + a_reg, saturating at 2^W-1 (no wrap); go to WAIT.
  - DISP: d=1 for this single cycle. On exit, tot <= 0 and next state is INIT.
- Coin event while in INIT, ADD or DISP:
  - Set pend=1 and capture a into a_reg.
  - pend is one-deep; a further event while pend=1 is dropped.
  - A pending coin is consumed on the next entry to WAIT.
- d is asserted only in DISP.
- Latency and ordering:
  - Coin edge sampled in WAIT at edge k: ADD at k+1, tot updated after k+2.
  - Earliest d is in the cycle after k+2; tot reads 0 after DISP.
  - A coin event and tot >= PRICE in the same WAIT cycle: the coin wins, so credit is added before vending.
- Value rules:
  - a=0 coin: a legal event; adds 0.
  - tot is only ever modified in ADD and on DISP exit.
- Reset mid-operation: any state returns immediately to INIT with tot=0 and d=0; pending coins are discarded.

Optional Feature:
- Macro: SODA_MACHINE_CARRY_CREDIT_EN.
- Defined: on DISP exit, tot <= tot - PRICE, so excess credit carries to the next vend. If the remainder is >= PRICE, a further vend follows after INIT/WAIT.
- Undefined: on DISP exit, tot <= 0; excess credit is forfeited.

Test Plan:
- Reset check: rst=0 with random c and a → tot=0, d=0. Release rst with c=0 → tot stays 0 and d stays 0 for 10 cycles.
- Exact payment:
  - Coin 25 (c high for 3 cycles), then coin 50 → tot steps 25, then 75.
  - d pulses one cycle; tot returns to 0.
  - Exactly one d pulse; a long c-high produced only one add.
- Overpayment, default build: coins 50, 50 → tot=100, one d pulse, tot=0.
- Overpayment, with SODA_MACHINE_CARRY_CREDIT_EN: coins 50, 50 → one d pulse, tot=25.
- Saturation: PRICE=255; coins 200 and 100 → tot=255 (not 44); d pulses once; tot=0.
- Coin during vend: coins 25, 50, with a third coin of 25 rising during DISP → one d pulse, then tot=25 via the pending path, with no further d.
- Async reset mid-ADD: assert rst between clock edges → tot=0 and d=0 immediately, without waiting for a clock edge.
